// File: rtl/conv_result_writer.sv
// conv_result_writer: buffers result pairs from the convolution core in a
// small FIFO and drains them into the single-port scratchpad, one byte per
// accepted cycle, honouring the scratchpad busy stall.
// Optional build macro: CONV_WB_DEDUP_EN -- skip the sum1 write when an
// entry's two destination addresses are equal (only sum2 is written).
module conv_result_writer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [DATA_W-1:0]        i_sum1,
    input  logic [DATA_W-1:0]        i_sum2,
    input  logic [ADDR_W-1:0]        i_dest1,
    input  logic [ADDR_W-1:0]        i_dest2,
    input  logic                     i_mem_busy,
    input  logic                     i_clr_ovf,
    output logic                     o_ready,
    output logic                     o_wr_en,
    output logic [ADDR_W-1:0]        o_wr_addr,
    output logic [DATA_W-1:0]        o_wr_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_busy,
    output logic                     o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE1 = 2'd1,
        WRITE2 = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] sum1_q  [DEPTH];
    logic [DATA_W-1:0] sum2_q  [DEPTH];
    logic [ADDR_W-1:0] dest1_q [DEPTH];
    logic [ADDR_W-1:0] dest2_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             full, push, pop, ovf_set;
    logic             head_skip, next_skip;

    assign full    = (count == CNT_W'(DEPTH));
    // The second write of the head entry retires it.
    assign pop     = (state == WRITE2) && !i_mem_busy;
    // A pop on the same edge frees the slot, so a push is legal even when full.
    assign push    = i_valid && (!full || pop);
    assign ovf_set = i_valid && full && !pop;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

`ifdef CONV_WB_DEDUP_EN
    logic [PTR_W-1:0] nxt_ptr;
    assign nxt_ptr   = rd_ptr + 1'b1;
    assign head_skip = (dest1_q[rd_ptr] == dest2_q[rd_ptr]);
    // After a pop the new head is either the next stored entry or, if the
    // FIFO held only one entry, the entry being pushed on this very edge.
    assign next_skip = (count > CNT_W'(1)) ? (dest1_q[nxt_ptr] == dest2_q[nxt_ptr])
                                           : (i_dest1 == i_dest2);
`else
    assign head_skip = 1'b0;
    assign next_skip = 1'b0;
`endif

    // FIFO storage; contents need no reset since pointers/count gate their use.
    always_ff @(posedge i_clk) begin
        if (push) begin
            sum1_q[wr_ptr]  <= i_sum1;
            sum2_q[wr_ptr]  <= i_sum2;
            dest1_q[wr_ptr] <= i_dest1;
            dest2_q[wr_ptr] <= i_dest2;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (ovf_set)
                o_overflow <= 1'b1;
            else if (i_clr_ovf)
                o_overflow <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (count != '0)
                    state_nxt = head_skip ? WRITE2 : WRITE1;
            WRITE1:
                if (!i_mem_busy)
                    state_nxt = WRITE2;
            WRITE2:
                if (!i_mem_busy) begin
                    if (count_next != '0)
                        state_nxt = next_skip ? WRITE2 : WRITE1;
                    else
                        state_nxt = IDLE;
                end
            default:
                state_nxt = IDLE;
        endcase
    end

    // Output decode from registered state and FIFO head only.
    always_comb begin
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_data = '0;
        case (state)
            WRITE1: begin
                o_wr_en   = 1'b1;
                o_wr_addr = dest1_q[rd_ptr];
                o_wr_data = sum1_q[rd_ptr];
            end
            WRITE2: begin
                o_wr_en   = 1'b1;
                o_wr_addr = dest2_q[rd_ptr];
                o_wr_data = sum2_q[rd_ptr];
            end
            default: ;
        endcase
    end

    assign o_ready = !full;
    assign o_count = count;
    assign o_busy  = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed testbench for conv_result_writer (DEPTH=4, ADDR_W=10, DATA_W=8).
module tb_conv_result_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] sum1, sum2;
    logic [9:0] dest1, dest2;
    logic       mem_busy;
    logic       clr_ovf;
    logic       ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] count;
    logic       busy;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Accepted-write log and scratchpad model
    logic [17:0] wr_log [0:63];
    int          n_wr = 0;
    logic [7:0]  mem_model [0:1023];

    // Hand-written entry table
    logic [7:0] t_s1 [0:4] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    logic [7:0] t_s2 [0:4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    logic [9:0] t_d1 [0:4] = '{10'h101, 10'h102, 10'h103, 10'h104, 10'h105};
    logic [9:0] t_d2 [0:4] = '{10'h201, 10'h202, 10'h203, 10'h204, 10'h205};

    int base;

    conv_result_writer #(.ADDR_W(10), .DATA_W(8), .DEPTH(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid),
        .i_sum1     (sum1),
        .i_sum2     (sum2),
        .i_dest1    (dest1),
        .i_dest2    (dest2),
        .i_mem_busy (mem_busy),
        .i_clr_ovf  (clr_ovf),
        .o_ready    (ready),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_count    (count),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en && !mem_busy) begin
            if (n_wr < 64) wr_log[n_wr] <= {wr_addr, wr_data};
            mem_model[wr_addr] <= wr_data;
            n_wr <= n_wr + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] s1, input logic [7:0] s2,
                        input logic [9:0] d1, input logic [9:0] d2);
        valid = 1'b1; sum1 = s1; sum2 = s2; dest1 = d1; dest2 = d2;
        tick();
        valid = 1'b0;
    endtask

    task automatic drain(input int expect_n);
        for (int i = 0; i < 40 && (n_wr - base) < expect_n; i++) tick();
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sum1 = '0; sum2 = '0; dest1 = '0; dest2 = '0;
        mem_busy = 1'b0; clr_ovf = 1'b0;
        repeat (2) tick();

        // Reset values
        check("rst_wr_en",  wr_en,    0);
        check("rst_addr",   wr_addr,  0);
        check("rst_data",   wr_data,  0);
        check("rst_count",  count,    0);
        check("rst_busy",   busy,     0);
        check("rst_ovf",    overflow, 0);
        check("rst_ready",  ready,    1);
        rst = 1'b0;
        tick();

        // Single pulse, no stall
        base = n_wr;
        push(8'h12, 8'h34, 10'h010, 10'h02C);          // E0
        check("t1_count_e0", count, 1);
        check("t1_wren_e0",  wr_en, 0);
        check("t1_busy_e0",  busy,  1);
        tick();                                         // E1
        check("t1_wren_e1",  wr_en,   1);
        check("t1_addr_e1",  wr_addr, 10'h010);
        check("t1_data_e1",  wr_data, 8'h12);
        tick();                                         // E2
        check("t1_nwr_e2",   n_wr - base, 1);
        check("t1_addr_e2",  wr_addr, 10'h02C);
        check("t1_data_e2",  wr_data, 8'h34);
        check("t1_count_e2", count, 1);
        tick();                                         // E3
        check("t1_nwr_e3",   n_wr - base, 2);
        check("t1_wren_e3",  wr_en, 0);
        check("t1_busy_e3",  busy,  0);
        check("t1_count_e3", count, 0);
        check("t1_log0",     wr_log[base],     {10'h010, 8'h12});
        check("t1_log1",     wr_log[base + 1], {10'h02C, 8'h34});

        // Stall for three cycles from E1
        base = n_wr;
        push(8'h12, 8'h34, 10'h010, 10'h02C);          // E0
        tick();                                         // E1
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin               // E2..E4
            tick();
            check("t2_hold_addr", wr_addr, 10'h010);
            check("t2_hold_data", wr_data, 8'h12);
            check("t2_hold_nwr",  n_wr - base, 0);
        end
        mem_busy = 1'b0;
        tick();                                         // E5
        check("t2_nwr_e5",  n_wr - base, 1);
        check("t2_addr_e5", wr_addr, 10'h02C);
        tick();                                         // E6
        check("t2_nwr_e6",  n_wr - base, 2);
        check("t2_wren_e6", wr_en, 0);

        // Five pushes while stalled: overflow on the fifth
        mem_busy = 1'b1;
        for (int k = 0; k < 4; k++) push(t_s1[k], t_s2[k], t_d1[k], t_d2[k]);
        check("t3_ready_full", ready,    0);
        check("t3_count_full", count,    4);
        check("t3_ovf_pre",    overflow, 0);
        push(t_s1[4], t_s2[4], t_d1[4], t_d2[4]);
        check("t3_count_drop", count,    4);
        check("t3_ovf_set",    overflow, 1);
        tick();
        check("t3_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_ovf_clr",    overflow, 0);
        base = n_wr;
        mem_busy = 1'b0;
        drain(8);
        check("t3_nwr",  n_wr - base, 8);
        check("t3_busy", busy, 0);
        for (int k = 0; k < 4; k++) begin
            check("t3_order_w1", wr_log[base + 2*k],     {t_d1[k], t_s1[k]});
            check("t3_order_w2", wr_log[base + 2*k + 1], {t_d2[k], t_s2[k]});
        end

        // Push while full coinciding with the WRITE2 pop
        mem_busy = 1'b1;
        for (int k = 0; k < 4; k++) push(t_s1[k], t_s2[k], t_d1[k], t_d2[k]);
        check("t4_count_full", count, 4);
        base = n_wr;
        mem_busy = 1'b0;
        tick();                                         // WRITE1 accepted
        check("t4_in_w2", wr_addr, t_d2[0]);
        push(t_s1[4], t_s2[4], t_d1[4], t_d2[4]);       // pop + push
        check("t4_count_same", count,    4);
        check("t4_ovf_clear",  overflow, 0);
        check("t4_ready",      ready,    0);
        drain(10);
        check("t4_nwr", n_wr - base, 10);
        check("t4_last_w1", wr_log[base + 8], {t_d1[4], t_s1[4]});
        check("t4_last_w2", wr_log[base + 9], {t_d2[4], t_s2[4]});

        // Equal destinations
        base = n_wr;
        push(8'hAA, 8'hBB, 10'h005, 10'h005);           // E0
        tick();                                         // E1
        check("t5_wren_e1", wr_en, 1);
        check("t5_addr_e1", wr_addr, 10'h005);
`ifdef CONV_WB_DEDUP_EN
        check("t5_data_e1", wr_data, 8'hBB);
        tick();                                         // E2
        check("t5_nwr_e2", n_wr - base, 1);
        drain(1);
        check("t5_nwr", n_wr - base, 1);
`else
        check("t5_data_e1", wr_data, 8'hAA);
        drain(2);
        check("t5_nwr", n_wr - base, 2);
`endif
        check("t5_mem", mem_model[10'h005], 8'hBB);

        // Reset during WRITE2 with three entries queued
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) push(t_s1[k], t_s2[k], t_d1[k], t_d2[k]);
        mem_busy = 1'b0;
        tick();
        check("t6_in_w2",  wr_addr, t_d2[0]);
        check("t6_count",  count,   3);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_wren",  wr_en,   0);
        check("t6_rst_count", count,   0);
        check("t6_rst_ready", ready,   1);
        check("t6_rst_busy",  busy,    0);
        check("t6_rst_addr",  wr_addr, 0);
        tick();
        rst = 1'b0;
        base = n_wr;
        repeat (6) tick();
        check("t6_no_writes", n_wr - base, 0);
        check("t6_idle_wren", wr_en, 0);
        push(8'h5A, 8'hC3, 10'h3F0, 10'h3F1);
        drain(2);
        check("t6_new_nwr",  n_wr - base, 2);
        check("t6_new_log",  wr_log[base + 1], {10'h3F1, 8'hC3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Write-back engine on the output side of the convolution pipeline. It accepts result pairs from the convolution core as a done pulse carrying two 8-bit sums and two destination addresses. Each pair is buffered in a small FIFO and drained into the single-write-port scratchpad, one byte per accepted cycle, honouring a memory busy stall. This lets the core start its next window while results are still being committed.

## Interface
- ADDR_W, 10, scratchpad address width
- DATA_W, 8, result byte width
- DEPTH, 4, FIFO entries (one entry = sum1, sum2, dest1, dest2); power of two, ≥2

- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high; clock i_clk
- i_valid  in  1  one-cycle result pulse from the convolution core (its done strobe)
- i_sum1, i_sum2  in  DATA_W  result bytes
- i_dest1, i_dest2  in  ADDR_W  destination addresses for sum1 and sum2
- i_mem_busy  in  1  scratchpad cannot accept a write this cycle
- i_clr_ovf  in  1  synchronous clear of o_overflow
- o_ready  out  1  FIFO not full (count < DEPTH)
- o_wr_en  out  1  write request to scratchpad
- o_wr_addr  out  ADDR_W  write address
- o_wr_data  out  DATA_W  write data
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy
- o_busy  out  1  FIFO non-empty or FSM not IDLE
- o_overflow  out  1  sticky: i_valid arrived while full

## Operation
- FIFO: circular, read/write pointers, separate count. Push on i_valid when count < DEPTH. Pop when the last write of the head entry is accepted.
- Push while full: entry dropped, FIFO unchanged, o_overflow set. o_overflow stays set until i_clr_ovf or reset. If i_clr_ovf and an overflowing push coincide, set wins.
- Simultaneous push and pop: both occur, count unchanged, legal even when full (pop frees the slot in the same edge).
- FSM states IDLE, WRITE1, WRITE2:
  - IDLE: count > 0 → WRITE1, else stay.
  - WRITE1: o_wr_en=1, addr=head.dest1, data=head.sum1. If !i_mem_busy → WRITE2, else hold.
  - WRITE2: o_wr_en=1, addr=head.dest2, data=head.sum2. If !i_mem_busy: pop, then → WRITE1 if count after pop > 0, else → IDLE. If busy, hold.
- A write is accepted on any edge where o_wr_en=1 and i_mem_busy=0. Address and data stay stable while held.
- Output decode is combinational from the registered state and the FIFO head only; i_valid never drives outputs directly.
- Order: entries drained in arrival order. Within an entry, sum1 is written before sum2, so sum2 wins on equal addresses.

## Timing
- Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_count=0, o_busy=0, o_overflow=0, o_ready=1. State=IDLE, pointers=0.
- Reset mid-operation: outputs take reset values immediately (async). Pending entries and the in-flight write are discarded.
- Latency, empty FIFO:
  - i_valid sampled at edge E0 → count=1 after E0.
  - FSM enters WRITE1 at E1 → o_wr_en high after E1.
  - With no stall, writes are accepted at E2 (dest1) and E3 (dest2).
- Throughput: 2 cycles per entry with no stall; WRITE2→WRITE1 has no idle bubble.
- o_ready and o_count reflect registered state. A push and its effect on o_ready are visible one cycle after the sampling edge.
- Each stalled cycle adds exactly one cycle of latency.

## Configuration
- CONV_WB_DEDUP_EN defined: WRITE1 is skipped when head.dest1 == head.dest2.
  - IDLE/WRITE2 go straight to WRITE2 for such entries.
  - Only sum2 is written, at 1 cycle per entry.
- Undefined: both writes are always issued as above; the final memory value is identical, but two writes are made.

## Test plan
- Single pulse, sums 0x12/0x34, dests 0x010/0x02C, no stall → writes (0x010,0x12) at E2, (0x02C,0x34) at E3; o_busy low after E3; o_count 1→0.
- Stall: i_mem_busy high for 3 cycles from E1 → (0x010,0x12) held stable, accepted at E5; second write accepted at E6.
- Five back-to-back pulses, DEPTH=4, i_mem_busy held high → o_ready falls after 4th push; 5th dropped; o_overflow=1 until i_clr_ovf; after release, exactly 8 writes in order.
- Push while full, coinciding with the WRITE2-accept pop → entry accepted, count stays 4, o_overflow stays 0.
- Equal dests 0x05/0x05, sums 0xAA/0xBB → memory ends 0xBB. With CONV_WB_DEDUP_EN, one write (0x05,0xBB) at E2; without it, two writes.
- Assert i_rst during WRITE2 with 3 entries queued → o_wr_en drops immediately; count=0; after release, no writes until a new i_valid.
